// File: rtl/fwd_stall_unit.sv
// Forwarding and hazard-control unit: EX operand bypass select, multi-cycle
// load-use stall sequencing, taken-branch flush and a saturating stall counter.
module fwd_stall_unit #(
  parameter int AW         = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs_id,
  input  logic [AW-1:0]    rt_id,
  input  logic             uses_rt_id,
  input  logic [AW-1:0]    rs_ex,
  input  logic [AW-1:0]    rt_ex,
  input  logic [AW-1:0]    wr_reg_ex,
  input  logic             regwrite_ex,
  input  logic             memread_ex,
  input  logic [AW-1:0]    wr_reg_mem,
  input  logic             regwrite_mem,
  input  logic             memread_mem,
  input  logic [AW-1:0]    wr_reg_wb,
  input  logic             regwrite_wb,
  input  logic             branch_taken_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LOAD_STALL - 1);
  localparam bit         MULTI    = (LOAD_STALL > 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             mem_ok, wb_ok, load_use, stall;
  logic [1:0]       sel_a, sel_b;

  // A load sitting in MEM has no data yet, so it is excluded as a bypass source.
  function automatic logic [1:0] bypass_sel(input logic [AW-1:0] src,
                                            input logic [AW-1:0] mem_dst,
                                            input logic          mem_en,
                                            input logic [AW-1:0] wb_dst,
                                            input logic          wb_en);
    if (mem_en && (mem_dst == src)) return 2'd2;
    if (wb_en && (wb_dst == src))   return 2'd1;
    return 2'd0;
  endfunction

  always_comb begin
    mem_ok   = regwrite_mem & (wr_reg_mem != '0) & !memread_mem;
    wb_ok    = regwrite_wb & (wr_reg_wb != '0);
    sel_a    = bypass_sel(rs_ex, wr_reg_mem, mem_ok, wr_reg_wb, wb_ok);
    sel_b    = bypass_sel(rt_ex, wr_reg_mem, mem_ok, wr_reg_wb, wb_ok);
    load_use = memread_ex & regwrite_ex & (wr_reg_ex != '0) &
               ((wr_reg_ex == rs_id) | (uses_rt_id & (wr_reg_ex == rt_id)));
    stall    = !branch_taken_ex &
               (((state_q == IDLE) & load_use) | (state_q == STALL));
  end

  // A taken branch squashes the stalled instruction, so any pending stall is dropped.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_count_d = stall_count_q;
    if (branch_taken_ex) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == STALL) begin
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (load_use && MULTI) begin
      state_d = STALL;
      cnt_d   = CNT_INIT;
    end
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Control outputs are held low for the whole reset assertion, not just after an edge.
  assign fwd_a       = rst_n ? sel_a : 2'd0;
  assign fwd_b       = rst_n ? sel_b : 2'd0;
  assign stall_if_id = rst_n & stall;
  assign bubble_ex   = rst_n & (stall | branch_taken_ex);
  assign flush_if_id = rst_n & branch_taken_ex;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Bench for fwd_stall_unit: three instances (LOAD_STALL 1/3/4, last with a
// 2-bit counter) share stimulus and are checked against a stall-debt model.
module tb_fwd_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_id, rt_id, rs_ex, rt_ex, wr_reg_ex, wr_reg_mem, wr_reg_wb;
  logic       uses_rt_id, regwrite_ex, memread_ex, regwrite_mem, memread_mem;
  logic       regwrite_wb, branch_taken_ex;

  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic        sif [3];
  logic        bub [3];
  logic        fl [3];
  logic [15:0] sc0, sc1;
  logic [1:0]  sc2;

  int total = 0;
  int bad   = 0;

  int ls   [3] = '{1, 3, 4};
  int cmax [3] = '{65535, 65535, 3};
  int rem  [3];
  int cnt  [3];

  always #5 clk = ~clk;

  fwd_stall_unit #(.AW(5), .LOAD_STALL(1), .CNT_W(16)) u_ls1 (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .wr_reg_ex(wr_reg_ex), .regwrite_ex(regwrite_ex),
    .memread_ex(memread_ex), .wr_reg_mem(wr_reg_mem), .regwrite_mem(regwrite_mem),
    .memread_mem(memread_mem), .wr_reg_wb(wr_reg_wb), .regwrite_wb(regwrite_wb),
    .branch_taken_ex(branch_taken_ex), .fwd_a(fa[0]), .fwd_b(fb[0]),
    .stall_if_id(sif[0]), .bubble_ex(bub[0]), .flush_if_id(fl[0]), .stall_count(sc0));

  fwd_stall_unit #(.AW(5), .LOAD_STALL(3), .CNT_W(16)) u_ls3 (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .wr_reg_ex(wr_reg_ex), .regwrite_ex(regwrite_ex),
    .memread_ex(memread_ex), .wr_reg_mem(wr_reg_mem), .regwrite_mem(regwrite_mem),
    .memread_mem(memread_mem), .wr_reg_wb(wr_reg_wb), .regwrite_wb(regwrite_wb),
    .branch_taken_ex(branch_taken_ex), .fwd_a(fa[1]), .fwd_b(fb[1]),
    .stall_if_id(sif[1]), .bubble_ex(bub[1]), .flush_if_id(fl[1]), .stall_count(sc1));

  fwd_stall_unit #(.AW(5), .LOAD_STALL(4), .CNT_W(2)) u_ls4 (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .wr_reg_ex(wr_reg_ex), .regwrite_ex(regwrite_ex),
    .memread_ex(memread_ex), .wr_reg_mem(wr_reg_mem), .regwrite_mem(regwrite_mem),
    .memread_mem(memread_mem), .wr_reg_wb(wr_reg_wb), .regwrite_wb(regwrite_wb),
    .branch_taken_ex(branch_taken_ex), .fwd_a(fa[2]), .fwd_b(fb[2]),
    .stall_if_id(sif[2]), .bubble_ex(bub[2]), .flush_if_id(fl[2]), .stall_count(sc2));

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int get_sc(input int i);
    if (i == 0) return int'(sc0);
    if (i == 1) return int'(sc1);
    return int'(sc2);
  endfunction

  function automatic int ref_fwd(input logic [4:0] src);
    if (regwrite_mem && wr_reg_mem != 0 && wr_reg_mem == src && !memread_mem) return 2;
    if (regwrite_wb && wr_reg_wb != 0 && wr_reg_wb == src) return 1;
    return 0;
  endfunction

  function automatic bit ref_load_use();
    return memread_ex && regwrite_ex && wr_reg_ex != 0 &&
           (wr_reg_ex == rs_id || (uses_rt_id && wr_reg_ex == rt_id));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0;
      cnt[i] = 0;
    end
  endtask

  task automatic clear_inputs();
    rs_id = 0; rt_id = 0; uses_rt_id = 0; rs_ex = 0; rt_ex = 0;
    wr_reg_ex = 0; regwrite_ex = 0; memread_ex = 0;
    wr_reg_mem = 0; regwrite_mem = 0; memread_mem = 0;
    wr_reg_wb = 0; regwrite_wb = 0; branch_taken_ex = 0;
  endtask

  // rem = stall cycles still owed after the current hazard cycle.
  task automatic step();
    bit lu, br, st;
    int nrem [3];
    int ncnt [3];
    @(negedge clk);
    lu = ref_load_use();
    br = branch_taken_ex;
    for (int i = 0; i < 3; i++) begin
      st = !br && (rem[i] > 0 || lu);
      chk($sformatf("fwd_a[%0d]", i), int'(fa[i]), ref_fwd(rs_ex));
      chk($sformatf("fwd_b[%0d]", i), int'(fb[i]), ref_fwd(rt_ex));
      chk($sformatf("stall[%0d]", i), int'(sif[i]), int'(st));
      chk($sformatf("bubble[%0d]", i), int'(bub[i]), int'(st || br));
      chk($sformatf("flush[%0d]", i), int'(fl[i]), int'(br));
      chk($sformatf("count[%0d]", i), get_sc(i), cnt[i]);
      ncnt[i] = (st && cnt[i] < cmax[i]) ? cnt[i] + 1 : cnt[i];
      if (br)              nrem[i] = 0;
      else if (rem[i] > 0) nrem[i] = rem[i] - 1;
      else if (lu)         nrem[i] = ls[i] - 1;
      else                 nrem[i] = 0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rem[i] = nrem[i];
      cnt[i] = ncnt[i];
    end
  endtask

  task automatic load_hazard(input logic [4:0] dst);
    memread_ex = 1; regwrite_ex = 1; wr_reg_ex = dst;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_stall[%0d]", i), int'(sif[i]), 0);
      chk($sformatf("rst_bubble[%0d]", i), int'(bub[i]), 0);
      chk($sformatf("rst_count[%0d]", i), get_sc(i), 0);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    model_reset();
    #13;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("init_fwd_a[%0d]", i), int'(fa[i]), 0);
      chk($sformatf("init_count[%0d]", i), get_sc(i), 0);
    end
    rst_n = 1;
    @(posedge clk);
    #1;

    // bypass priority
    wr_reg_mem = 5; wr_reg_wb = 5; rs_ex = 5; regwrite_mem = 1; regwrite_wb = 1;
    #1 chk("byp_mem", int'(fa[0]), 2);
    step();
    regwrite_mem = 0;
    #1 chk("byp_wb", int'(fa[0]), 1);
    step();
    rs_ex = 0; wr_reg_mem = 0; wr_reg_wb = 0; regwrite_mem = 1;
    #1 chk("byp_r0", int'(fa[0]), 0);
    step();

    // load in MEM is never a bypass source
    clear_inputs();
    memread_mem = 1; regwrite_mem = 1; wr_reg_mem = 9; rs_ex = 9; wr_reg_wb = 9; regwrite_wb = 1;
    #1 chk("mem_load_fwd", int'(fa[0]), 1);
    step();

    // single load-use hazard via rt
    do_reset();
    clear_inputs();
    load_hazard(8); rt_id = 8; uses_rt_id = 1;
    #1 chk("lu_stall1", int'(sif[0]), 1);
    step();
    clear_inputs();
    for (int k = 0; k < 5; k++) step();
    chk("ls1_total", get_sc(0), 1);
    chk("ls3_total", get_sc(1), 3);
    chk("ls4_sat", get_sc(2), 3);
    load_hazard(8); rt_id = 8; uses_rt_id = 0;
    #1 chk("no_rt_use", int'(sif[0]), 0);
    step();
    clear_inputs();

    // branch in the 2nd stall cycle of LOAD_STALL=4
    do_reset();
    load_hazard(3); rs_id = 3;
    step();
    clear_inputs();
    branch_taken_ex = 1;
    #1 chk("br_stall", int'(sif[2]), 0);
    chk("br_bubble", int'(bub[2]), 1);
    chk("br_flush", int'(fl[2]), 1);
    step();
    clear_inputs();
    #1 chk("br_after", int'(sif[2]), 0);
    chk("br_count", get_sc(2), 1);
    step();

    // asynchronous reset in the middle of a stall
    load_hazard(4); rs_id = 4;
    step();
    #2 rst_n = 0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_stall[%0d]", i), int'(sif[i]), 0);
      chk($sformatf("async_bubble[%0d]", i), int'(bub[i]), 0);
      chk($sformatf("async_fwd[%0d]", i), int'(fa[i]), 0);
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) step();
    chk("post_rst_cnt", get_sc(1), 0);

    // continuous hazards saturate the 2-bit counter
    load_hazard(6); rs_id = 6;
    for (int k = 0; k < 8; k++) step();
    chk("sat_hold", get_sc(2), 3);
    clear_inputs();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      rs_id           = 5'($urandom_range(0, 3));
      rt_id           = 5'($urandom_range(0, 3));
      uses_rt_id      = 1'($urandom_range(0, 1));
      rs_ex           = 5'($urandom_range(0, 3));
      rt_ex           = 5'($urandom_range(0, 3));
      wr_reg_ex       = 5'($urandom_range(0, 3));
      regwrite_ex     = ($urandom_range(0, 3) != 0);
      memread_ex      = ($urandom_range(0, 2) == 0);
      wr_reg_mem      = 5'($urandom_range(0, 3));
      regwrite_mem    = 1'($urandom_range(0, 1));
      memread_mem     = ($urandom_range(0, 3) == 0);
      wr_reg_wb       = 5'($urandom_range(0, 3));
      regwrite_wb     = 1'($urandom_range(0, 1));
      branch_taken_ex = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_stall_unit.md
# fwd_stall_unit

Parametrised forwarding and hazard-control unit for the five-stage pipelined datapath. It selects the ALU operand bypass source for EX (EX/MEM, MEM/WB or register file) and generates multi-cycle load-use stalls through a small state machine, so memories with longer load latency can be used. It also flushes on taken branches and keeps a saturating stall-cycle counter for performance measurement. It sits beside the ID/EX register, driving the two EX operand muxes, the PC/IF-ID write enables and the ID/EX bubble insert.

## Interface
Parameters:
- AW, 5: register-address width.
- LOAD_STALL, 1: bubble cycles per load-use hazard (legal 1..15).
- CNT_W, 16: width of stall_count.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs_id, rt_id  in  AW  source registers of the instruction in ID.
- uses_rt_id  in  1  instruction in ID reads rt; store or R-type.
- rs_ex, rt_ex  in  AW  source registers of the instruction in EX.
- wr_reg_ex, regwrite_ex, memread_ex  in  AW,1,1  destination, write enable and load flag in EX.
- wr_reg_mem, regwrite_mem, memread_mem  in  AW,1,1  same signals for the MEM stage.
- wr_reg_wb, regwrite_wb  in  AW,1  destination and write enable for the WB stage.
- branch_taken_ex  in  1  taken branch resolved in EX.
- fwd_a, fwd_b  out  2  operand source for rs/rt: 0 = register file, 1 = MEM/WB, 2 = EX/MEM; 3 is never driven.
- stall_if_id  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load NOP into ID/EX.
- flush_if_id  out  1  zero IF/ID.
- stall_count  out  CNT_W  saturating count of stalled cycles.

## Operation
- Register 0 is never a hazard source. Every compare needs a nonzero destination and its write enable set.
- Forwarding for fwd_a (rs_ex); fwd_b (rt_ex) works the same way:
  - MEM match with memread_mem = 0 gives 2.
  - Otherwise a WB match gives 1.
  - Otherwise 0.
  - A MEM-stage load is never a bypass source. It falls through to the WB check.
- load_use = memread_ex & regwrite_ex & (wr_reg_ex != 0) & (wr_reg_ex == rs_id | (uses_rt_id & wr_reg_ex == rt_id)).
- FSM states are IDLE and STALL, with a 4-bit counter cnt.
  - In IDLE, load_use with LOAD_STALL > 1 moves to STALL and sets cnt = LOAD_STALL-1.
  - In STALL, cnt == 1 returns to IDLE; otherwise cnt decrements.
  - In STALL the load_use input is ignored, because the stall is already committed.
- Outputs:
  - stall_if_id = bubble_ex = !branch_taken_ex & ((IDLE & load_use) | STALL).
  - flush_if_id = branch_taken_ex.
  - bubble_ex is also set whenever branch_taken_ex is 1.
- Taken branch while in STALL: the state goes to IDLE and cnt goes to 0 on that edge. The stall is abandoned because the stalled instruction is squashed.
- stall_count increments on every edge where stall_if_id = 1 and holds at 2^CNT_W-1.
- Reset sets state IDLE, cnt 0 and stall_count 0. While rst_n = 0, stall_if_id, bubble_ex, flush_if_id, fwd_a and fwd_b are forced to 0. Asserting reset mid-stall aborts the stall immediately and asynchronously.

## Timing
- fwd_a and fwd_b are combinational from EX, MEM and WB inputs, with zero-cycle latency.
- The stall is asserted combinationally in the detection cycle. Total stalled cycles per hazard = LOAD_STALL exactly, with LOAD_STALL-1 of them in STALL.
- With LOAD_STALL = 1, STALL is never entered and the classic single bubble results.
- branch_taken_ex has priority over a stall in the same cycle. In that cycle stall_if_id = 0, bubble_ex = 1 and flush_if_id = 1.
- stall_count updates on the edge after each stalled cycle.

## Test plan
- Bypass priority: wr_reg_mem = wr_reg_wb = rs_ex = 5, both write enables 1, memread_mem = 0 -> fwd_a = 2. Clear regwrite_mem -> fwd_a = 1. Set rs_ex = 0 with wr_reg_mem = wr_reg_wb = 0 -> fwd_a = 0.
- Load-use, LOAD_STALL = 1: memread_ex = 1, wr_reg_ex = 8, rt_id = 8, uses_rt_id = 1 -> stall and bubble high for exactly 1 cycle; stall_count = 1. Repeat with uses_rt_id = 0 -> no stall.
- Load-use, LOAD_STALL = 3: hazard for one cycle, then memread_ex dropped -> stall high for exactly 3 consecutive cycles; stall_count = 3.
- Load in MEM: memread_mem = 1, wr_reg_mem = rs_ex = 9, wr_reg_wb = 9, regwrite_wb = 1 -> fwd_a = 1 (never 2).
- Branch during STALL (LOAD_STALL = 4): branch_taken_ex in the 2nd stall cycle -> flush and bubble high, stall low that cycle; state is IDLE next cycle; stall_count = 1.
- Reset mid-stall: assert rst_n = 0 asynchronously in STALL -> all outputs 0 immediately; after release, no residual stall and stall_count = 0. Saturation check with CNT_W = 2 and continuous hazards -> stall_count holds at 3.
